// File: rtl/full_stage_error_ctrl_pkg.sv
// Shared definitions for the full-connected stage error controller.
//   err_state_t  : tap-update sequencer states (IDLE, ARMED, UPDATE)
//   DEF_*        : default widths/depths used by the controller parameters
//   float_24_8_t : error word layout (24-bit mantissa, 8-bit exponent)
package full_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_UPDATE = 2'd2
  } err_state_t;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_CNT_W      = 4;
  localparam int unsigned DEF_NUM_PHASES = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [23:0] mantissa;
    logic [7:0]  exponent;
  } float_24_8_t;

endpackage

// File: rtl/full_stage_error_ctrl_if.sv
// Back-propagated error stream (valid/ready).
//   err_data : error word (float_24_8 payload)
//   err_vld  : source has a word
//   err_rdy  : sink accepts the word this cycle
// master = error source, slave = controller.
interface full_stage_error_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] err_data;
  logic              err_vld;
  logic              err_rdy;

  modport master (output err_data, output err_vld, input err_rdy);
  modport slave  (input err_data, input err_vld, output err_rdy);
endinterface

// File: rtl/full_stage_error_ctrl_delay_line.sv
// full_delay_line: 1-bit shift register, synchronous active-high reset.
//   clk, reset : clock / synchronous reset
//   d          : input bit
//   q          : d delayed by DLY cycles (DLY = 0 gives a wire)
module full_delay_line #(
  parameter int unsigned DLY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (DLY == 0) begin : g_comb
      logic w_unused;
      assign w_unused = clk ^ reset;
      assign q = d;
    end else begin : g_reg
      logic [DLY-1:0] r_sh;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sh <= '0;
        end else begin
          r_sh[0] <= d;
          for (int unsigned i = 1; i < DLY; i++) begin
            r_sh[i] <= r_sh[i-1];
          end
        end
      end
      assign q = r_sh[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/full_stage_error_ctrl.sv
// full_stage_error_ctrl: error-feedback controller for one full-connected stage.
// Accepts the error stream, counts taps / write addresses / phases, keeps a
// credit count of pending error blocks and sequences the tap-update window.
//   clk, reset          : clock, synchronous active-high reset
//   error_tap_length    : last tap index of an error block
//   load_length         : last write index per phase
//   input_stage         : stage is the network input (forces tap update)
//   state_finish        : end-of-pass strobe
//   read_finish         : tap read complete
//   err_if (slave)      : err_data / err_vld / err_rdy
//   error_*             : pass-through data, counters, depth, update strobes
//   stage_error_*       : MODE_DLY-delayed strobes to the upstream stage
// Optional (macro FULL_ERR_STALL_STAT_EN): stall_cycles, overflow_sticky.
module full_stage_error_ctrl
  import full_err_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned NUM_PHASES = DEF_NUM_PHASES,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WR_HAZ_DLY = 4,
  parameter int unsigned LATCH_DLY  = 6,
  parameter int unsigned MODE_DLY   = 2,
  localparam int unsigned PHASE_W   = $clog2(NUM_PHASES),
  localparam int unsigned DEPTH_W   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CNT_W-1:0]    error_tap_length,
  input  logic [CNT_W-1:0]    load_length,
  input  logic                input_stage,
  input  logic                state_finish,
  input  logic                read_finish,
  full_stage_error_ctrl_if.slave err_if,
  output logic [DATA_W-1:0]   error_value,
  output logic                error_valid,
  output logic [CNT_W-1:0]    error_count,
  output logic [CNT_W-1:0]    error_sub_address,
  output logic [PHASE_W-1:0]  error_phase,
  output logic [PHASE_W-1:0]  error_phase_read,
  output logic [DEPTH_W-1:0]  error_depth,
  output logic                error_update_mode,
  output logic                error_update_latch,
  output logic                error_update_first,
  output logic                error_tap_update_out,
  output logic                error_finish_tap,
  output logic                stage_error_mode,
  output logic                stage_error_first
`ifdef FULL_ERR_STALL_STAT_EN
  ,
  output logic [15:0]         stall_cycles,
  output logic                overflow_sticky
`endif
);

  err_state_t         r_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_sub_addr;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_phase_read;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_tap_update;
  logic               r_latch;
  logic               r_first_int;
  logic               r_update_last;

  logic w_full, w_rdy, w_xfer, w_block_finish, w_sub_wrap;
  logic w_mode, w_first, w_wr_vld, w_push, w_pop;
  logic w_wr_vld_d, w_latch_d;

  assign w_full         = (r_depth == DEPTH_W'(FIFO_DEPTH));
  assign w_rdy          = ~w_full & ~w_wr_vld_d & ~w_latch_d;
  assign w_xfer         = err_if.err_vld & w_rdy;
  assign w_block_finish = w_xfer & (r_count == error_tap_length);
  assign w_sub_wrap     = w_xfer & (r_sub_addr == load_length);
  assign w_mode         = (r_depth != '0);
  assign w_first        = r_first_int & r_latch;
  assign w_wr_vld       = r_latch & ~w_first;
  assign w_push         = w_block_finish & r_tap_update;
  assign w_pop          = r_update_last & r_tap_update;

  assign err_if.err_rdy       = w_rdy;
  assign error_value          = err_if.err_data;
  assign error_valid          = w_xfer;
  assign error_count          = r_count;
  assign error_sub_address    = r_sub_addr;
  assign error_phase          = r_phase;
  assign error_phase_read     = r_phase_read;
  assign error_depth          = r_depth;
  assign error_update_mode    = w_mode;
  assign error_update_latch   = r_latch;
  assign error_update_first   = w_first;
  assign error_tap_update_out = r_tap_update & ~input_stage;
  assign error_finish_tap     = state_finish & r_latch;

  // Counters, tap-update toggle and pending-block credit count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_sub_addr   <= '0;
      r_phase      <= '0;
      r_depth      <= '0;
      r_tap_update <= 1'b1;
    end else begin
      if (w_xfer) begin
        r_count    <= w_block_finish ? '0 : r_count + CNT_W'(1);
        r_sub_addr <= w_sub_wrap ? '0 : r_sub_addr + CNT_W'(1);
        if (w_sub_wrap) begin
          r_phase <= (r_phase == PHASE_W'(NUM_PHASES - 1)) ? '0 : r_phase + PHASE_W'(1);
        end
      end
      if (input_stage) begin
        r_tap_update <= 1'b1;
      end else if (r_update_last) begin
        r_tap_update <= ~r_tap_update;
      end
      // Simultaneous push and pop cancel; a pop with nothing pending is dropped.
      if (w_push && !w_pop) begin
        r_depth <= r_depth + DEPTH_W'(1);
      end else if (w_pop && !w_push && (r_depth != '0)) begin
        r_depth <= r_depth - DEPTH_W'(1);
      end
    end
  end

  // Update sequencer. Every state_finish reloads latch from mode, so an
  // end-of-pass in IDLE with nothing pending releases a stale latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_latch       <= 1'b0;
      r_first_int   <= 1'b0;
      r_update_last <= 1'b0;
      r_phase_read  <= '0;
    end else begin
      r_first_int   <= 1'b0;
      r_update_last <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (state_finish) begin
            r_latch <= w_mode;
            if (w_mode) r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (state_finish) r_latch <= w_mode;
          if (read_finish) begin
            r_state     <= ST_UPDATE;
            r_first_int <= 1'b1;
            if (r_tap_update) begin
              r_phase_read <= (r_phase_read == PHASE_W'(NUM_PHASES - 1)) ?
                              '0 : r_phase_read + PHASE_W'(1);
            end
          end
        end
        ST_UPDATE: begin
          if (state_finish) begin
            r_state       <= ST_IDLE;
            r_update_last <= w_mode;
            r_latch       <= w_mode;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  full_delay_line #(.DLY(WR_HAZ_DLY)) u_dly_wr_vld (
    .clk(clk), .reset(reset), .d(w_wr_vld), .q(w_wr_vld_d));
  full_delay_line #(.DLY(LATCH_DLY)) u_dly_latch (
    .clk(clk), .reset(reset), .d(r_latch), .q(w_latch_d));
  full_delay_line #(.DLY(MODE_DLY)) u_dly_first (
    .clk(clk), .reset(reset), .d(w_first), .q(stage_error_first));
  full_delay_line #(.DLY(MODE_DLY)) u_dly_mode (
    .clk(clk), .reset(reset), .d(r_latch), .q(stage_error_mode));

`ifdef FULL_ERR_STALL_STAT_EN
  logic [15:0] r_stall;
  logic        r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (err_if.err_vld && !w_rdy && (r_stall != '1)) r_stall <= r_stall + 16'd1;
      if ((w_pop && (r_depth == '0)) || (w_block_finish && w_full)) r_overflow <= 1'b1;
    end
  end

  assign stall_cycles    = r_stall;
  assign overflow_sticky = r_overflow;
`endif

endmodule

// File: doc/full_stage_error_ctrl.md
Name: full_stage_error_ctrl

Overview:
Parametrised error-feedback controller for one stage of the full-connected pipeline.
- Accepts the back-propagated error stream through a valid/ready handshake.
- Counts taps, write addresses and phases, and tracks pending error blocks in a credit FIFO of configurable depth.
- Sequences the tap-update window: first/last/latch/mode strobes to the tap memory and to the upstream stage.
- Generalises the fixed 2-deep, 4-phase, fixed-delay controller with configurable depth, phase count and pipeline delays, plus an explicit update state machine.

Parameters:
- DATA_W, 32, error word width (float_24_8 payload)
- CNT_W, 4, tap/write counter width
- NUM_PHASES, 4, phase count (>=2); PHASE_W = clog2(NUM_PHASES)
- FIFO_DEPTH, 2, max pending error blocks (1..7); DEPTH_W = clog2(FIFO_DEPTH+1)
- WR_HAZ_DLY, 4, cycles from write-address-valid to rdy block (1..8)
- LATCH_DLY, 6, cycles from update latch to rdy block (1..8)
- MODE_DLY, 2, delay of stage_error_mode/first outputs (0..8)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- error_tap_length  in  CNT_W  last tap index of an error block
- load_length  in  CNT_W  last write index per phase
- input_stage  in  1  stage is network input; forces tap-update enable
- state_finish  in  1  end-of-pass strobe from stage sequencer
- read_finish  in  1  tap read complete
- err_data  in  DATA_W  error word
- err_vld  in  1  error valid
- err_rdy  out  1  error ready
- error_value  out  DATA_W  err_data pass-through
- error_valid  out  1  err_vld & err_rdy
- error_count  out  CNT_W  tap index
- error_sub_address  out  CNT_W  write address
- error_phase  out  PHASE_W  write phase
- error_phase_read  out  PHASE_W  read phase
- error_depth  out  DEPTH_W  pending blocks
- error_update_mode, error_update_latch, error_update_first, error_tap_update_out, error_finish_tap  out  1  update strobes
- stage_error_mode, stage_error_first  out  1  delayed strobes to upstream stage

Behaviour:
- Reset: all counters, phases, depth, strobes and delay lines = 0; tap_update = 1; FSM = IDLE; err_rdy = 1 on the first cycle after reset.
- Handshake: xfer = err_vld & err_rdy.
  - err_rdy = ~full & ~wr_vld_d[WR_HAZ_DLY] & ~latch_d[LATCH_DLY].
  - full = (depth == FIFO_DEPTH).
  - Data is never registered; error_value is combinational.
- Counters on xfer:
  - error_count wraps to 0 when equal to error_tap_length; that xfer is block_finish.
  - error_sub_address wraps to 0 when equal to load_length.
  - error_phase increments on that wrap, modulo NUM_PHASES.
- tap_update:
  - Set to 1 while input_stage is high.
  - Otherwise toggles on update_last.
  - error_tap_update_out = tap_update & ~input_stage.
- Depth update, applied when block_finish & tap_update is true:
  - block_finish & pop: hold.
  - block_finish only: +1.
  - pop only: -1.
  - pop = update_last & tap_update.
  - Push while full cannot occur (rdy is low). Pop at depth 0 is ignored and depth saturates at 0.
- error_update_mode = depth != 0.
- FSM, 3 states:
  - IDLE -> ARMED on state_finish & mode; latch <= 1.
  - ARMED -> UPDATE on read_finish; first_int pulses 1 cycle; error_phase_read increments modulo NUM_PHASES if tap_update.
  - UPDATE -> IDLE on state_finish; update_last pulses 1 cycle if depth != 0; latch <= mode.
  - state_finish in ARMED: latch reloads from mode; FSM stays in ARMED.
- Strobes:
  - error_update_latch = latch register.
  - error_update_first = first_int & latch.
  - error_finish_tap = state_finish & latch.
  - wr_vld = latch & ~error_update_first.
- Delays: stage_error_mode = latch delayed MODE_DLY; stage_error_first = (first_int & latch) delayed MODE_DLY. MODE_DLY=0 means combinational.
- Reset mid-operation: returns everything to the reset state within one cycle. No partial block survives.

Optional Feature:
- Macro: FULL_ERR_STALL_STAT_EN
- Defined: adds outputs stall_cycles (16 bit, saturating count of cycles with err_vld & ~err_rdy) and overflow_sticky (set by pop at depth 0 or block_finish when full). Both are cleared only by reset.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package full_err_pkg: FSM state enum (IDLE, ARMED, UPDATE), default widths, float_24_8 typedef reuse.
- Sub-module full_delay_line: parametrised 1-bit shift register (DLY, synchronous reset). Instantiated for wr_vld, latch, first and mode.

Test Plan:
- Reset then 3 blocks with error_tap_length=3, load_length=1 and no state_finish -> depth goes 1 then 2; err_rdy=0 after the 8th xfer; error_phase=0,1,2,3 then wraps to 0.
- depth=1, state_finish, read_finish 2 cycles later, state_finish -> latch=1; error_update_first pulses once; stage_error_mode rises MODE_DLY cycles after latch; depth drops to 0 after update_last.
- Latch asserted -> err_rdy low WR_HAZ_DLY cycles after wr_vld; stays low until latch_d clears.
- block_finish and pop in the same cycle at depth=1 -> depth stays 1.
- input_stage=1 across update_last -> tap_update stays 1 and error_tap_update_out=0.
- FULL_ERR_STALL_STAT_EN defined, err_vld held high for 10 cycles while full -> stall_cycles=10; reset clears it.
